// File: rtl/serial_receiver.sv
// serial_receiver: 8N1 UART receive path with a small receive FIFO.
//
// Ports
//   core_clock         clock, rising edge
//   reset              synchronous, active-high
//   serial_rx          asynchronous serial line (idle high)
//   rx_data[7:0]       FIFO head byte, 8'h00 when empty (combinational read)
//   rx_data_available  FIFO non-empty
//   rx_ready           consumer pop (effective when rx_data_available)
//   rx_count           FIFO occupancy, $clog2(FIFO_DEPTH)+1 bits
//   overrun            sticky: a good byte was dropped on a full FIFO
//   framing_error      sticky: a stop bit was sampled low
//   clear_errors       one-cycle pulse clearing both sticky flags
//
// Parameters
//   CLOCKS_PER_BIT (>= 8), FIFO_DEPTH (power of 2, >= 2)
//
// Build option
//   SERIAL_RX_MAJORITY_VOTE_EN: each bit decision is the majority of rx_s at
//   target-2, target-1 and target counts instead of a single sample.
module serial_receiver #(
  parameter int CLOCKS_PER_BIT = 52,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          core_clock,
  input  logic                          reset,
  input  logic                          serial_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_data_available,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          framing_error,
  input  logic                          clear_errors
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_next;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_val;
  logic          clr_cnt, sample_data, push, ferr_evt;

  // Two-flop synchronizer, reset to the idle level so reset never fakes a start.
  always_ff @(posedge core_clock) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], serial_rx};
  end
  assign rx_s = sync_q[1];

`ifdef SERIAL_RX_MAJORITY_VOTE_EN
  // hist[0] holds rx_s from one cycle ago, hist[1] from two; inside a state
  // the counter advances every cycle, so at the target count these are the
  // target-1 and target-2 samples.
  logic [1:0] hist;
  always_ff @(posedge core_clock) begin
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], rx_s};
  end
  assign bit_val = (hist[0] & hist[1]) | (hist[0] & rx_s) | (hist[1] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge core_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    clr_cnt     = 1'b0;
    sample_data = 1'b0;
    push        = 1'b0;
    ferr_evt    = 1'b0;
    case (state)
      IDLE: begin
        clr_cnt = 1'b1;
        if (!rx_s) state_next = START;
      end
      START: if (cnt == HALF_LAST) begin
        clr_cnt    = 1'b1;
        state_next = bit_val ? IDLE : DATA;  // high at mid-start = glitch
      end
      DATA: if (cnt == BIT_LAST) begin
        clr_cnt     = 1'b1;
        sample_data = 1'b1;
        if (bit_idx == 3'd7) state_next = STOP;
      end
      STOP: if (cnt == BIT_LAST) begin
        clr_cnt = 1'b1;
        if (bit_val) begin
          push       = 1'b1;
          state_next = IDLE;
        end else begin
          ferr_evt   = 1'b1;
          state_next = BREAK;
        end
      end
      BREAK: begin
        clr_cnt = 1'b1;
        if (rx_s) state_next = IDLE;  // one error per low period
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge core_clock) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt <= clr_cnt ? '0 : cnt + 1'b1;
      if (state == IDLE) bit_idx <= '0;
      else if (sample_data) bit_idx <= bit_idx + 1'b1;
      if (sample_data) shift <= {bit_val, shift[7:1]};  // LSB first
    end
  end

  // Receive FIFO; occupancy disambiguates full from empty with equal pointers.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_pop, do_push, ovf_evt;

  assign full     = (rx_count == FULL_CNT);
  assign do_pop   = rx_data_available && rx_ready;
  assign do_push  = push && (!full || do_pop);
  assign ovf_evt  = push && full && !do_pop;
  assign rx_data_available = (rx_count != '0);
  assign rx_data  = rx_data_available ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge core_clock) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge core_clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rx_count      <= '0;
      overrun       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      rx_count <= rx_count + 1'b1;
      else if (do_pop && !do_push) rx_count <= rx_count - 1'b1;
      // set wins over a coincident clear
      overrun       <= (overrun & ~clear_errors) | ovf_evt;
      framing_error <= (framing_error & ~clear_errors) | ferr_evt;
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: directed frames plus randomized
// frames/pops checked against a queue-based model of the receive behaviour.
module tb_serial_receiver;
  localparam int CPB   = 52;
  localparam int DEPTH = 8;
  localparam int HALF  = CPB / 2;
  // Negedge offset (from the start-bit negedge) at which rx_ready must be high
  // so that the pop lands on the stop-sample edge: 2 sync cycles + detect
  // cycle, half a bit, then 9 full bits, minus one for the set-up cycle.
  localparam int STOP_POP_AT = 2 + HALF + 9 * CPB;

  logic       core_clock = 0;
  logic       reset = 1;
  logic       serial_rx = 1;
  logic [7:0] rx_data;
  logic       rx_data_available;
  logic       rx_ready = 0;
  logic [3:0] rx_count;
  logic       overrun, framing_error;
  logic       clear_errors = 0;

  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic m_ov = 0, m_fe = 0;

  serial_receiver #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .core_clock(core_clock), .reset(reset), .serial_rx(serial_rx),
    .rx_data(rx_data), .rx_data_available(rx_data_available),
    .rx_ready(rx_ready), .rx_count(rx_count), .overrun(overrun),
    .framing_error(framing_error), .clear_errors(clear_errors));

  always #5 core_clock = ~core_clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge core_clock);
  endtask

  // Drive one frame; glitch_at inverts the line for one cycle at that negedge
  // offset, pop_at raises rx_ready for one cycle at that offset.
  task automatic send(input logic [7:0] d, input logic stop, input int glitch_at, input int pop_at);
    for (int i = 0; i < 10 * CPB; i++) begin
      int b;
      logic v;
      @(negedge core_clock);
      b = i / CPB;
      v = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
      if (i == glitch_at) v = ~v;
      serial_rx = v;
      rx_ready  = (i == pop_at);
    end
    rx_ready = 0;
  endtask

  // Model of what a completed frame does to the FIFO and flags.
  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop) m_fe = 1;
    else if (q.size() < DEPTH) q.push_back(d);
    else m_ov = 1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, rx_count, q.size());
    chk({tag, ".avail"}, rx_data_available, q.size() != 0);
    chk({tag, ".data"}, rx_data, q.size() != 0 ? q[0] : 8'h00);
    chk({tag, ".ov"}, overrun, m_ov);
    chk({tag, ".fe"}, framing_error, m_fe);
  endtask

  task automatic pop_one(input string tag);
    chk({tag, ".head"}, rx_data, q.size() != 0 ? q[0] : 8'h00);
    rx_ready = 1;
    @(negedge core_clock);
    rx_ready = 0;
    if (q.size() != 0) void'(q.pop_front());
    chk({tag, ".cnt"}, rx_count, q.size());
  endtask

  task automatic clear();
    clear_errors = 1;
    @(negedge core_clock);
    clear_errors = 0;
    m_ov = 0;
    m_fe = 0;
  endtask

  task automatic bad_frame_recover(input logic [7:0] d, input int low_bits);
    send(d, 1'b0, -1, -1);
    model_frame(d, 1'b0);
    idle(low_bits * CPB);
    serial_rx = 1;
    idle(CPB);
  endtask

  initial begin
    idle(4);
    check_state("reset");
    reset = 0;
    idle(CPB);

    // two bytes back to back
    send(8'h55, 1, -1, -1); model_frame(8'h55, 1);
    send(8'hA3, 1, -1, -1); model_frame(8'hA3, 1);
    check_state("two");
    chk("two.peak", rx_count, 2);
    pop_one("two.p0");
    pop_one("two.p1");
    pop_one("two.empty");
    check_state("two.end");

    // short low pulse is rejected at the start-bit midpoint
    serial_rx = 0; idle(20); serial_rx = 1; idle(2 * CPB);
    check_state("glitch");

    // framing error, held-low line, then a good byte
    bad_frame_recover(8'h7E, 5);
    check_state("ferr");
    send(8'h12, 1, -1, -1); model_frame(8'h12, 1);
    check_state("ferr.next");
    clear();
    check_state("ferr.clr");
    pop_one("ferr.pop");

    // overrun: nine bytes with no pops
    for (int i = 1; i <= 9; i++) begin
      send(8'(i), 1, -1, -1);
      model_frame(8'(i), 1);
    end
    check_state("ovr");
    for (int i = 0; i < DEPTH; i++) pop_one("ovr.pop");
    clear();
    for (int i = 0; i < DEPTH; i++) begin
      send(8'h20 + 8'(i), 1, -1, -1);
      model_frame(8'h20 + 8'(i), 1);
    end
    // pop exactly on the stop-sample edge while full: accepted, no overrun
    send(8'h99, 1, -1, STOP_POP_AT);
    void'(q.pop_front());
    model_frame(8'h99, 1);
    check_state("full.pp");
    while (q.size() != 0) pop_one("full.drain");

    // reset in the middle of DATA bits
    serial_rx = 0; idle(3 * CPB);
    reset = 1; idle(3);
    chk("rst.count", rx_count, 0);
    serial_rx = 1; idle(5);
    reset = 0; idle(2 * CPB);
    send(8'hC4, 1, -1, -1); model_frame(8'hC4, 1);
    check_state("rst.c4");
    pop_one("rst.pop");

    // one-cycle high glitch on the bit-3 sample of 0x00
    send(8'h00, 1, HALF + 4 * CPB, -1);
`ifdef SERIAL_RX_MAJORITY_VOTE_EN
    q.push_back(8'h00);
`else
    q.push_back(8'h08);
`endif
    check_state("vote");
    pop_one("vote.pop");

    // randomized frames, stop errors, pops and clears
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic st;
      int pops;
      d  = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      if (st) begin
        send(d, 1, -1, -1);
        model_frame(d, 1);
      end else begin
        bad_frame_recover(d, 1);
      end
      check_state("rnd");
      pops = $urandom_range(0, 2);
      for (int k = 0; k < pops; k++) pop_one("rnd.pop");
      if ($urandom_range(0, 3) == 0) begin
        clear();
        check_state("rnd.clr");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_receiver.md
# serial_receiver

UART receive path, the counterpart to `serial_transmitter`: it deserializes 8N1 frames from the board's serial RX pin and buffers received bytes in a small FIFO. It sits in the board top level beside the transmitter, on `core_clock`. The FIFO side is a valid/ready pop interface that the top-level memory-mapped I/O decode uses to serve core loads from the RX data and status registers.

## Interface
- `CLOCKS_PER_BIT`, default 52: `core_clock` cycles per serial bit (6 MHz / 115200). Must be ≥ 8.
- `FIFO_DEPTH`, default 8: receive FIFO entries. Must be a power of 2, ≥ 2.
- `core_clock`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `serial_rx`  in  1  asynchronous serial line. Idle is high.
- `rx_data`  out  8  FIFO head byte. Reads 8'h00 when the FIFO is empty.
- `rx_data_available`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer pop. A byte pops on a cycle where `rx_data_available && rx_ready`.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overrun`  out  1  sticky: a valid byte was dropped because the FIFO was full.
- `framing_error`  out  1  sticky: a stop bit was sampled low.
- `clear_errors`  in  1  one-cycle pulse that clears both sticky flags.

## Operation
- `serial_rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Bit counter: 0..CLOCKS_PER_BIT-1. Bit index: 0..7.
- State machine:
  - IDLE: `rx_s`==0 → START, counter cleared.
  - START: at counter == CLOCKS_PER_BIT/2-1, sample the line. If 0 → DATA with counter cleared. If 1, it was a glitch → IDLE.
  - DATA: at counter == CLOCKS_PER_BIT-1, sample into the shift register LSB-first and increment the bit index. After bit 7 → STOP.
  - STOP: at counter == CLOCKS_PER_BIT-1, sample the line.
    - 1: push the byte → IDLE.
    - 0: set `framing_error`, discard the byte → BREAK.
  - BREAK: wait for `rx_s`==1 → IDLE. A held-low line yields exactly one framing error.
- Push while full with no simultaneous pop: byte dropped, `overrun` set, FIFO contents unchanged.
- Push and pop in the same cycle:
  - Always accepted. `rx_count` unchanged.
  - When full, this is not an overrun.
  - When empty, the push occurs and the pop is impossible, since `rx_data_available` is 0.
- FIFO pointers are log2(FIFO_DEPTH) bits, wrap naturally, and use the `rx_count` value to distinguish full from empty.
- Flags:
  - `clear_errors` clears both flags.
  - If an error event coincides with `clear_errors`, the flag ends set (set wins).
- Reset mid-frame: the frame is abandoned, FIFO emptied, flags cleared, state IDLE. A line still low after reset is treated as a new start bit.

## Timing
- Reset values: `rx_data`=8'h00, `rx_data_available`=0, `rx_count`=0, `overrun`=0, `framing_error`=0. Internal state IDLE; synchronizer flops at 1.
- Start detection lags the pin by 2 cycles (synchronizer).
- Data samples fall near mid-bit. The stop bit is sampled 9.5 bit periods after detection.
- The pushed byte is visible on `rx_data`, `rx_data_available` and `rx_count` in the cycle after the stop sample edge.
- The pop takes effect at the clock edge. The next head byte (or 8'h00 and `available`=0) appears the following cycle.
- `rx_data` is combinational from the FIFO memory and read pointer, with no extra register.
- Back-to-back frames: the next start bit can be detected from the first IDLE cycle after STOP. No inter-frame gap is required.

## Configuration
- `SERIAL_RX_MAJORITY_VOTE_EN` defined:
  - Each sample point (start, data, stop) takes 3 samples of `rx_s`, at counter target-2, target-1 and target.
  - The bit value is the majority of the three, and the decision is made at target.
  - This rejects single-cycle glitches.
- Not defined: a single sample of `rx_s` at the target count.
- Frame timing and outputs are otherwise identical in both builds.

## Test plan
- Send 0x55 then 0xA3 at CLOCKS_PER_BIT=52 → `rx_data` reads 0x55 then 0xA3, `rx_count` peaks at 2, no flags. Popping with `rx_ready`=1 empties the FIFO.
- Pulse `serial_rx` low for 20 cycles (< half bit) → no byte, `rx_count`=0, no flags, state back at IDLE.
- Send a frame with the stop bit low (data 0x7E) → `framing_error`=1, `rx_count`=0. Hold the line low 5 bit periods, then send 0x12 → only 0x12 received, still one error. `clear_errors` → flag 0.
- Send 9 bytes 0x01..0x09 with `rx_ready`=0 → `rx_count`=8, `overrun`=1, FIFO pops 0x01..0x08. Then hold `rx_ready`=1 through the stop sample of a 10th byte arriving while full → accepted, no new overrun event.
- Assert `reset` during the DATA bits of a frame, release, send 0xC4 → only 0xC4 received, flags 0.
- With `SERIAL_RX_MAJORITY_VOTE_EN`: inject a 1-cycle high glitch exactly at the bit-3 sample of 0x00 → byte received as 0x00. Without the macro, the same stimulus → 0x08.
